// File: rtl/order_link_tx_if.sv
// rtl/order_link_tx_if.sv - order word push handshake between order entry and the link transmitter
interface order_link_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] order_in;
  logic              order_valid;
  logic              order_ready;

  modport master (output order_in, output order_valid, input order_ready);
  modport slave  (input order_in, input order_valid, output order_ready);
endinterface

// File: rtl/order_link_tx.sv
// rtl/order_link_tx.sv - buffered MSB-first serial transmitter for the order link
// Words queue in a FIFO; each is framed by com_en_out with optional even parity.
module order_link_tx #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int BIT_DIV   = 3,
  parameter int PARITY_EN = 1,
  parameter int GAP_CYC   = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  order_link_tx_if.slave           ord,
  output logic                     data_out,
  output logic                     com_en_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam int TMAX  = (BIT_DIV > GAP_CYC) ? BIT_DIV : GAP_CYC;
  localparam int TIM_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_PARITY, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ready_q, ready_d;
  logic                overflow_q, overflow_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TIM_W-1:0]    tim_q, tim_d;
  logic                push_ok, pop;

  // Push acceptance looks only at the pre-edge count, so a simultaneous pop never frees a slot early.
  always_comb begin
    push_ok    = ord.order_valid && (count_q < CNT_W'(DEPTH));
    pop        = (state_q == S_LOAD);
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    overflow_d = overflow_q | (ord.order_valid & ~push_ok);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CNT_W'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    idx_d   = idx_q;
    tim_d   = tim_q;
    case (state_q)
      S_IDLE: if (count_q != '0) state_d = S_LOAD;
      S_LOAD: begin
        shift_d = mem_q[rd_ptr_q];
        par_d   = ^mem_q[rd_ptr_q];
        idx_d   = IDX_W'(DATA_W - 1);
        tim_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (tim_q == TIM_W'(BIT_DIV - 1)) begin
          tim_d = '0;
          if (idx_q == '0) state_d = (PARITY_EN != 0) ? S_PARITY : S_GAP;
          else             idx_d   = idx_q - IDX_W'(1);
        end else begin
          tim_d = tim_q + TIM_W'(1);
        end
      end
      S_PARITY: begin
        if (tim_q == TIM_W'(BIT_DIV - 1)) begin
          tim_d   = '0;
          state_d = S_GAP;
        end else begin
          tim_d = tim_q + TIM_W'(1);
        end
      end
      S_GAP: begin
        if (tim_q == TIM_W'(GAP_CYC - 1)) begin
          tim_d   = '0;
          state_d = S_IDLE;
        end else begin
          tim_d = tim_q + TIM_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      idx_q      <= '0;
      tim_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      idx_q      <= idx_d;
      tim_q      <= tim_d;
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem_q[wr_ptr_q] <= ord.order_in;
  end

  always_comb begin
    com_en_out = (state_q == S_SHIFT) || (state_q == S_PARITY);
    data_out   = 1'b0;
    if (state_q == S_SHIFT)  data_out = shift_q[idx_q];
    if (state_q == S_PARITY) data_out = par_q;
  end

  assign ord.order_ready = ready_q;
  assign busy            = (state_q != S_IDLE);
  assign fifo_count      = count_q;
  assign overflow        = overflow_q;
endmodule
